fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Round-robin arbiter sharing the single push port of one fifo_sr / cdc_fifo_sr source side among REQS requesters.
- Supports multi-beat packets: once a requester wins, it keeps the port until it pushes a beat flagged last, so packets are never interleaved in the FIFO.
- Uses the FIFO's src_num_avail as credit and never pushes into a full FIFO.
- Sits between producer units (e.g. decode/issue slices) and a shared queue.

Parameters:
- WIDTH, 32: data width; equals the FIFO WIDTH.
- REQS, 4: number of requesters, minimum 2.
- DEPTH, 8: depth of the attached FIFO, power of 2; sizes the credit input.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous reset, active-high.
- req  in  REQS: per-requester beat valid. Held with data until granted.
- req_data  in  REQS x WIDTH: per-requester beat payload.
- req_last  in  REQS: beat is the final beat of its packet.
- gnt  out  REQS: one-hot or zero, combinational. Beat accepted this cycle.
- push  out  1: registered push to FIFO.
- dinp  out  WIDTH: registered data to FIFO.
- src_num_avail  in  $clog2(DEPTH)+1: free entries reported by FIFO.
- owner_vld  out  1: a packet is in progress (LOCKED).
- owner_id  out  $clog2(REQS): current or last owner.

Behaviour:
- Reset (rst high at posedge): state=IDLE, rr_ptr=0, owner_id=0, owner_vld=0, push=0, dinp=0. gnt is forced to 0 combinationally whenever rst is high.
- Credit:
  - credit_ok = (src_num_avail > push). The registered push of the previous grant is not yet reflected in src_num_avail.
  - Pops are seen late; this is conservative and acceptable.
  - No gnt is asserted unless credit_ok.
- State IDLE:
  - Winner is the first i with req[i], scanning from rr_ptr upward modulo REQS.
  - If credit_ok and a winner exists: gnt[winner]=1.
  - If !req_last[winner]: go to LOCKED, owner_id=winner, owner_vld=1.
  - Else: stay in IDLE, rr_ptr=winner+1 mod REQS, owner_id=winner.
- State LOCKED:
  - Only the owner can be granted: gnt[owner_id]=req[owner_id] & credit_ok.
  - Other requesters wait regardless of credit.
  - Granted beat with req_last: go to IDLE, owner_vld=0, rr_ptr=owner_id+1 mod REQS.
  - An owner deasserting req mid-packet stalls the port. There is no timeout; the owner keeps the lock.
- Datapath:
  - On any gnt, push<=1 and dinp<=req_data[granted] at the next edge. Latency from grant to FIFO push is 1 cycle.
  - Otherwise push<=0; dinp holds its value.
  - Maximum rate is one beat per cycle.
- Simultaneous events:
  - A single-beat packet in IDLE is granted and released in the same cycle.
  - Back-to-back single-beat packets from different requesters occur on consecutive cycles.
- Full FIFO (src_num_avail==0, or ==1 with push high): gnt=0 and state is unchanged.
- Reset mid-packet: the lock is dropped and the partial packet already in the FIFO stays there. Upstream is reset by the same rst.
- Widths: rr_ptr and owner_id wrap modulo REQS (non-power-of-2 REQS is legal). Compare src_num_avail at full width against zero-extended push.

Decomposition:
- Shared package: arb_state_t enum {ARB_IDLE, ARB_LOCKED}; function rr_pick(req, ptr) returning found flag and index.
- One sub-module: rr_priority_pick (combinational rotate + priority find). Reused later by other arbiters.
- FSM, credit logic and output registers stay in the top module.

Test Plan:
1. Reset with all req high: gnt=0 during rst; first cycle after, gnt=4'b0001 (rr_ptr=0); push=1 on the next cycle.
2. req=4'b1111 continuously, all last=1, src_num_avail=8 constant: grants rotate 0,1,2,3,0 on consecutive cycles, and dinp follows the granted data one cycle later.
3. Requester 2 sends a 3-beat packet (last on beat 3) while req 0 and 1 are high: gnt=4'b0100 for 3 cycles, then the next grant goes to requester 3 if requesting, else 0. No interleave in the FIFO.
4. Credit limit, src_num_avail held at 1 with one req: one grant, next cycle gnt=0 (push=1 outstanding). Grants resume once src_num_avail reflects the free entry.
5. Owner drops req mid-packet for 5 cycles while others request: gnt=0 for all 5 cycles, owner_vld stays 1, and the owner resumes afterwards.
6. rst asserted in LOCKED mid-packet: next cycle owner_vld=0, push=0, rr_ptr=0, and arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_push_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_push_arbiter_pkg
//
// Purpose:
//    Shared types and helpers for the FIFO push arbiter and for any other
//    round-robin arbiter that wants the same pick function.
//
// Contents:
//    arb_state_t  - arbiter FSM states (ARB_IDLE, ARB_LOCKED)
//    RR_MAX_REQS  - largest requester count the rr_pick helper supports
//    RR_IDX_W     - index width of the rr_pick helper
//    rr_pick_t    - result of a round-robin pick (found flag + index)
//    rr_pick()    - scan a request vector from a start pointer upward,
//                   wrapping modulo the live requester count
// ---------------------------------------------------------------------------
package fifo_push_arbiter_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam int RR_MAX_REQS = 32;
   localparam int RR_IDX_W    = 5;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // The request vector is zero-extended to RR_MAX_REQS by the caller and
   // n gives the number of live requesters.  Positions are visited in the
   // order ptr, ptr+1, ... wrapping at n, so the first set bit found is the
   // round-robin winner.  Because ptr < n and only the first n offsets are
   // considered, a single conditional subtract performs the wrap.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQS-1:0] req,
                                        input logic [RR_IDX_W-1:0]    ptr,
                                        input logic [RR_IDX_W:0]      n);
      rr_pick_t            res;
      logic [RR_IDX_W:0]   pos;
      res.found = 1'b0;
      res.idx   = '0;
      for (int i = 0; i < RR_MAX_REQS; i++) begin
         pos = {1'b0, ptr} + (RR_IDX_W+1)'(i);
         if (pos >= n) begin
            pos = pos - n;
         end
         if (((RR_IDX_W+1)'(i) < n) && !res.found && req[pos[RR_IDX_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = pos[RR_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//
// Purpose:
//    Combinational round-robin pick: rotate the request vector so the
//    scan starts at ptr, then take the first asserted request.  Pure logic,
//    no state, so it can be dropped into any arbiter.
//
// Parameters:
//    REQS  - number of requesters (2 .. RR_MAX_REQS, need not be 2^n)
//
// Ports:
//    req    in   REQS     request vector
//    ptr    in   IDX_W    first position to consider (must be < REQS)
//    found  out  1        at least one request is asserted
//    idx    out  IDX_W    index of the winning request (0 when !found)
// ---------------------------------------------------------------------------
module rr_priority_pick
   import fifo_push_arbiter_pkg::*;
#(
   parameter  int REQS  = 4,
   localparam int IDX_W = $clog2(REQS)
) (
   input  logic [REQS-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   rr_pick_t pick;

   always_comb begin
      pick = rr_pick(RR_MAX_REQS'(req), RR_IDX_W'(ptr), (RR_IDX_W+1)'(REQS));
   end

   // The helper only ever returns indices below REQS; the full-width range
   // check is a defensive guard that keeps a corrupt index from ever being
   // reported as a valid winner.
   assign found = pick.found && ({1'b0, pick.idx} < (RR_IDX_W+1)'(REQS));
   assign idx   = pick.idx[IDX_W-1:0];

endmodule

// File: rtl/fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_push_arbiter
//
// Purpose:
//    Shares the single push port of one FIFO source side among REQS
//    producers.  Arbitration is round-robin per packet: once a requester
//    wins with a non-last beat it owns the port until it pushes a beat
//    flagged last, so packets never interleave in the FIFO.  The FIFO's
//    free-entry count is used as credit and the FIFO is never overfilled.
//
// Parameters:
//    WIDTH  - data width (matches the FIFO)
//    REQS   - number of requesters, at least 2
//    DEPTH  - depth of the attached FIFO (power of 2)
//
// Ports:
//    clk            in   1             clock
//    rst            in   1             synchronous reset, active high
//    req            in   REQS          per-requester beat valid
//    req_data       in   REQS x WIDTH  per-requester beat payload
//    req_last       in   REQS          beat is last of its packet
//    gnt            out  REQS          combinational beat accept, one-hot/0
//    push           out  1             registered FIFO push
//    dinp           out  WIDTH         registered FIFO data
//    src_num_avail  in   log2(DEPTH)+1 free FIFO entries
//    owner_vld      out  1             a packet is in progress
//    owner_id       out  log2(REQS)    current or last owner
// ---------------------------------------------------------------------------
module fifo_push_arbiter
   import fifo_push_arbiter_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int REQS    = 4,
   parameter  int DEPTH   = 8,
   localparam int IDX_W   = $clog2(REQS),
   localparam int AVAIL_W = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [REQS-1:0]            req,
   input  logic [REQS-1:0][WIDTH-1:0] req_data,
   input  logic [REQS-1:0]            req_last,
   output logic [REQS-1:0]            gnt,
   output logic                       push,
   output logic [WIDTH-1:0]           dinp,
   input  logic [AVAIL_W-1:0]         src_num_avail,
   output logic                       owner_vld,
   output logic [IDX_W-1:0]           owner_id
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQS - 1);

   arb_state_t       state_q,     state_d;
   logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
   logic [IDX_W-1:0] owner_id_q,  owner_id_d;
   logic             owner_vld_q, owner_vld_d;
   logic             push_q,      push_d;
   logic [WIDTH-1:0] dinp_q,      dinp_d;

   logic             credit_ok;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx;

   // Pointer increment that wraps at REQS rather than at 2^IDX_W, so
   // non-power-of-two requester counts rotate correctly.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      return (v == LAST_IDX) ? '0 : v + 1'b1;
   endfunction

   rr_priority_pick #(
      .REQS  (REQS)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // The beat pushed last cycle is not yet reflected in src_num_avail, so
   // it is subtracted here.  Pops are likewise seen late, which only makes
   // the credit check conservative.
   assign credit_ok = (src_num_avail > AVAIL_W'(push_q));

   // Next-state and grant decode.  In IDLE the round-robin winner is
   // granted; a non-last beat locks the port to it.  In LOCKED only the
   // owner may push, and a stalled owner simply holds the lock.  Reset
   // suppresses any grant so no beat is consumed from upstream while the
   // arbiter is being cleared.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_id_d  = owner_id_q;
      owner_vld_d = owner_vld_q;
      gnt_vld     = 1'b0;
      gnt_idx     = '0;

      case (state_q)
         ARB_IDLE: begin
            if (credit_ok && pick_found) begin
               gnt_vld    = 1'b1;
               gnt_idx    = pick_idx;
               owner_id_d = pick_idx;
               if (!req_last[pick_idx]) begin
                  state_d     = ARB_LOCKED;
                  owner_vld_d = 1'b1;
               end else begin
                  rr_ptr_d = wrap_inc(pick_idx);
               end
            end
         end
         ARB_LOCKED: begin
            if (credit_ok && req[owner_id_q]) begin
               gnt_vld = 1'b1;
               gnt_idx = owner_id_q;
               if (req_last[owner_id_q]) begin
                  state_d     = ARB_IDLE;
                  owner_vld_d = 1'b0;
                  rr_ptr_d    = wrap_inc(owner_id_q);
               end
            end
         end
         default: begin
            state_d     = ARB_IDLE;
            owner_vld_d = 1'b0;
         end
      endcase

      if (rst) begin
         gnt_vld = 1'b0;
      end
   end

   // Grant vector and the one-cycle push pipeline.  dinp only loads when a
   // beat is accepted so the FIFO input stays quiet between pushes.
   always_comb begin
      gnt    = '0;
      push_d = gnt_vld;
      dinp_d = dinp_q;
      if (gnt_vld) begin
         gnt[gnt_idx] = 1'b1;
         dinp_d       = req_data[gnt_idx];
      end
   end

   // State and output registers.  Reset drops any lock; a partial packet
   // already pushed stays in the FIFO since upstream is reset alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         owner_id_q  <= '0;
         owner_vld_q <= 1'b0;
         push_q      <= 1'b0;
         dinp_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_id_q  <= owner_id_d;
         owner_vld_q <= owner_vld_d;
         push_q      <= push_d;
         dinp_q      <= dinp_d;
      end
   end

   assign push      = push_q;
   assign dinp      = dinp_q;
   assign owner_vld = owner_vld_q;
   assign owner_id  = owner_id_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Directed bench for fifo_push_arbiter with REQS=4, DEPTH=8, WIDTH=32.
// Each requester presents a payload tagged with its id and a per-requester
// beat sequence number; a beat is replaced by the next one only after it has
// been granted.  Every expected grant pushes the granted payload onto a
// scoreboard queue, which is popped when the DUT raises push.
// ---------------------------------------------------------------------------
module tb_fifo_push_arbiter;

   localparam int WIDTH = 32;
   localparam int REQS  = 4;
   localparam int DEPTH = 8;

   logic                       clk;
   logic                       rst;
   logic [REQS-1:0]            req;
   logic [REQS-1:0][WIDTH-1:0] req_data;
   logic [REQS-1:0]            req_last;
   logic [REQS-1:0]            gnt;
   logic                       push;
   logic [WIDTH-1:0]           dinp;
   logic [3:0]                 src_num_avail;
   logic                       owner_vld;
   logic [1:0]                 owner_id;

   int          check_count = 0;
   int          pass_count  = 0;
   int          fail_count  = 0;
   int          seq [REQS];
   logic [31:0] exp_q [$];

   fifo_push_arbiter #(
      .WIDTH (WIDTH),
      .REQS  (REQS),
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_data      (req_data),
      .req_last      (req_last),
      .gnt           (gnt),
      .push          (push),
      .dinp          (dinp),
      .src_num_avail (src_num_avail),
      .owner_vld     (owner_vld),
      .owner_id      (owner_id)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so a broken DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mkData(input int id, input int s);
      return {8'(160 + id), 24'(s)};
   endfunction

   // Single comparison point: counts every check and reports failures.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive all inputs; each requester shows its current beat.
   task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                input logic [3:0] lst, input logic [3:0] avail);
      rst           = r;
      req           = rq;
      req_last      = lst;
      src_num_avail = avail;
      for (int i = 0; i < REQS; i++) begin
         req_data[i] = mkData(i, seq[i]);
      end
   endtask

   // One clock cycle: check gnt before the edge, record the expected push,
   // then after the edge check push and pop the scoreboard against dinp.
   // A granted requester then advances to its next beat.
   task automatic checkOutput(input string tag, input logic [3:0] exp_gnt);
      int          g;
      logic [31:0] exp_data;
      @(negedge clk);
      check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
      g = -1;
      for (int i = 0; i < REQS; i++) begin
         if (exp_gnt[i]) g = i;
      end
      if (g >= 0) exp_q.push_back(req_data[g]);
      @(posedge clk);
      #1;
      check({tag, "_push"}, 32'(push), (g >= 0) ? 32'd1 : 32'd0);
      if (push === 1'b1) begin
         check({tag, "_sb_nonempty"}, (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_q.size() != 0) begin
            exp_data = exp_q.pop_front();
            check({tag, "_dinp"}, dinp, exp_data);
         end
      end
      if (g >= 0) begin
         seq[g]++;
         req_data[g] = mkData(g, seq[g]);
      end
   endtask

   initial begin
      for (int i = 0; i < REQS; i++) seq[i] = 0;

      // Reset with every requester asking: nothing may be granted.
      applyStimulus(1'b1, 4'b1111, 4'b1111, 4'd8);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      @(posedge clk);
      #1;
      check("rst_push",      32'(push),      32'd0);
      check("rst_dinp",      dinp,           32'd0);
      check("rst_owner_vld", 32'(owner_vld), 32'd0);
      check("rst_owner_id",  32'(owner_id),  32'd0);

      // Single-beat packets from all four: grants rotate 0,1,2,3,0,1.
      applyStimulus(1'b0, 4'b1111, 4'b1111, 4'd8);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("rot%0d", k), 4'b0001 << (k % 4));
      end

      // Requester 2 owns a 3-beat packet while 0 and 1 keep asking.
      applyStimulus(1'b0, 4'b0111, 4'b0011, 4'd8);
      checkOutput("pkt_b1", 4'b0100);
      check("pkt_owner_vld", 32'(owner_vld), 32'd1);
      check("pkt_owner_id",  32'(owner_id),  32'd2);
      checkOutput("pkt_b2", 4'b0100);
      applyStimulus(1'b0, 4'b0111, 4'b0111, 4'd8);
      checkOutput("pkt_b3", 4'b0100);
      check("pkt_release", 32'(owner_vld), 32'd0);
      checkOutput("pkt_next", 4'b0001);
      applyStimulus(1'b0, 4'b0000, 4'b1111, 4'd8);
      checkOutput("pkt_idle", 4'b0000);

      // Credit: one free entry allows a single beat until it is refilled.
      applyStimulus(1'b0, 4'b0010, 4'b1111, 4'd1);
      checkOutput("cr_first", 4'b0010);
      checkOutput("cr_inflight", 4'b0000);
      applyStimulus(1'b0, 4'b0010, 4'b1111, 4'd0);
      checkOutput("cr_full", 4'b0000);
      applyStimulus(1'b0, 4'b0010, 4'b1111, 4'd1);
      checkOutput("cr_resume", 4'b0010);

      // Owner 2 stalls mid-packet for five cycles; the lock holds.
      applyStimulus(1'b0, 4'b1111, 4'b1011, 4'd8);
      checkOutput("stall_start", 4'b0100);
      applyStimulus(1'b0, 4'b1011, 4'b1011, 4'd8);
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("stall%0d", k), 4'b0000);
         check($sformatf("stall%0d_vld", k), 32'(owner_vld), 32'd1);
         check($sformatf("stall%0d_id", k),  32'(owner_id),  32'd2);
      end
      applyStimulus(1'b0, 4'b1111, 4'b1111, 4'd8);
      checkOutput("stall_resume", 4'b0100);
      checkOutput("stall_after", 4'b1000);

      // Reset while requester 1 holds the port mid-packet.
      applyStimulus(1'b0, 4'b0010, 4'b1101, 4'd8);
      checkOutput("mid_lock", 4'b0010);
      check("mid_owner_id", 32'(owner_id), 32'd1);
      applyStimulus(1'b1, 4'b1111, 4'b1111, 4'd8);
      checkOutput("mid_rst", 4'b0000);
      check("mid_rst_vld", 32'(owner_vld), 32'd0);
      check("mid_rst_id",  32'(owner_id),  32'd0);
      applyStimulus(1'b0, 4'b1111, 4'b1111, 4'd8);
      checkOutput("mid_restart", 4'b0001);
      applyStimulus(1'b0, 4'b0000, 4'b1111, 4'd8);
      checkOutput("drain", 4'b0000);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
